legv8_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the LEGv8 datapath; successor to the single-cycle opcode decoder.

---
 rtl/legv8_ctrl_pkg.sv | 46 ++++
 rtl/legv8_multicycle_ctrl_if.sv | 30 +++
 rtl/legv8_op_decode.sv | 26 ++
 rtl/legv8_multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared constants and types for the LEGv8 multi-cycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package legv8_ctrl_pkg;

    localparam int OPC_W = 11;
    localparam int ALU_W = 3;
    localparam int CNT_W = $clog2(16);

    // Opcode values and don't-care masks (mask bit 1 = bit is compared)
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_MUL  = 11'b10011011000;
    localparam logic [OPC_W-1:0] OPC_SDIV = 11'b10011010110;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b10110100000;
    localparam logic [OPC_W-1:0] OPC_B    = 11'b00010100000;
    localparam logic [OPC_W-1:0] MASK_ALL = 11'b11111111111;
    localparam logic [OPC_W-1:0] MASK_CBZ = 11'b11111111000;
    localparam logic [OPC_W-1:0] MASK_B   = 11'b11111100000;

    // ALU operation encodings
    localparam logic [ALU_W-1:0] ALU_NONE  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_DIV   = 3'b011;
    localparam logic [ALU_W-1:0] ALU_MUL   = 3'b100;
    localparam logic [ALU_W-1:0] ALU_PASSB = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_ERR
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_RADD, CLS_RSUB, CLS_RMUL, CLS_RDIV,
        CLS_LOAD, CLS_STORE, CLS_CBZ, CLS_B
    } cls_t;

    function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                       input logic [OPC_W-1:0] val,
                                       input logic [OPC_W-1:0] mask);
        return (opc & mask) == (val & mask);
    endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Instruction handshake plus datapath control bundle for the multi-cycle controller.
// Latency: n/a (wires only).
// Backpressure: instr_ready from the controller gates acceptance of instr_valid.
interface legv8_multicycle_ctrl_if;
    logic                              instr_valid;
    logic [legv8_ctrl_pkg::OPC_W-1:0]  opcode;
    logic                              zero_flag;
    logic                              instr_ready;
    logic [legv8_ctrl_pkg::ALU_W-1:0]  alu_op;
    logic                              mux2;
    logic                              mux3;
    logic                              mem_read_dm;
    logic                              mem_write_dm;
    logic                              reg_write_rf;
    logic                              branch;
    logic                              done;
    logic                              illegal_op;

    modport master (
        output instr_valid, opcode, zero_flag,
        input  instr_ready, alu_op, mux2, mux3, mem_read_dm, mem_write_dm,
               reg_write_rf, branch, done, illegal_op
    );

    modport slave (
        input  instr_valid, opcode, zero_flag,
        output instr_ready, alu_op, mux2, mux3, mem_read_dm, mem_write_dm,
               reg_write_rf, branch, done, illegal_op
    );
endinterface

// File: rtl/legv8_op_decode.sv
// Classifies an 11-bit LEGv8 opcode into an instruction class.
// Latency: combinational.
// Backpressure: none.
module legv8_op_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output cls_t             op_cls,
    output logic             illegal
);

    // Priority-free match: the supported encodings do not overlap under their masks
    always_comb begin
        op_cls = CLS_NONE;
        if      (opc_match(opcode, OPC_ADD,  MASK_ALL)) op_cls = CLS_RADD;
        else if (opc_match(opcode, OPC_SUB,  MASK_ALL)) op_cls = CLS_RSUB;
        else if (opc_match(opcode, OPC_MUL,  MASK_ALL)) op_cls = CLS_RMUL;
        else if (opc_match(opcode, OPC_SDIV, MASK_ALL)) op_cls = CLS_RDIV;
        else if (opc_match(opcode, OPC_LDUR, MASK_ALL)) op_cls = CLS_LOAD;
        else if (opc_match(opcode, OPC_STUR, MASK_ALL)) op_cls = CLS_STORE;
        else if (opc_match(opcode, OPC_CBZ,  MASK_CBZ)) op_cls = CLS_CBZ;
        else if (opc_match(opcode, OPC_B,    MASK_B))   op_cls = CLS_B;
        illegal = (op_cls == CLS_NONE);
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: IDLE->DECODE->EXEC[->MEM][->WB], illegal ops via ERR.
// Latency: accept->done 2..4 cycles, MUL/SDIV stretch EXEC to MUL_LAT/DIV_LAT cycles.
// Backpressure: instr_ready high only in IDLE; one instruction in flight at a time.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 11,
    parameter int ALU_OP_W = 3,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    legv8_multicycle_ctrl_if.slave bus
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("MUL_LAT must be in 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
        $error("DIV_LAT must be in 1..15");
    end
    if (OPCODE_W != OPC_W || ALU_OP_W != ALU_W) begin : g_bad_width
        $error("OPCODE_W/ALU_OP_W must match the package widths");
    end

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    cls_t             dec_cls;
    logic             dec_illegal;

    legv8_op_decode u_decode (
        .opcode  (bus.opcode),
        .op_cls  (dec_cls),
        .illegal (dec_illegal)
    );

    // State, latched class, EXEC stall counter and captured zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    // Next state plus Moore outputs decoded from state and latched class
    always_comb begin
        state_d          = state_q;
        cls_d            = cls_q;
        cnt_d            = cnt_q;
        zero_d           = zero_q;
        bus.instr_ready  = 1'b0;
        bus.alu_op       = ALU_NONE;
        bus.mux2         = 1'b0;
        bus.mux3         = 1'b0;
        bus.mem_read_dm  = 1'b0;
        bus.mem_write_dm = 1'b0;
        bus.reg_write_rf = 1'b0;
        bus.branch       = 1'b0;
        bus.done         = 1'b0;
        bus.illegal_op   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    cls_d   = dec_illegal ? CLS_NONE : dec_cls;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // zero_flag is captured entering EXEC so branch stays a pure
                // register output for CBZ's single EXEC cycle
                zero_d = bus.zero_flag;
                if (cls_q == CLS_NONE) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_EXEC;
                    cnt_d   = (cls_q == CLS_RMUL) ? MUL_CNT :
                              (cls_q == CLS_RDIV) ? DIV_CNT : '0;
                end
            end
            ST_EXEC: begin
                unique case (cls_q)
                    CLS_RADD:  bus.alu_op = ALU_ADD;
                    CLS_RSUB:  bus.alu_op = ALU_SUB;
                    CLS_RMUL:  bus.alu_op = ALU_MUL;
                    CLS_RDIV:  bus.alu_op = ALU_DIV;
                    CLS_LOAD,
                    CLS_STORE: begin
                        bus.alu_op = ALU_ADD;
                        bus.mux2   = 1'b1;
                    end
                    CLS_CBZ: begin
                        bus.alu_op = ALU_PASSB;
                        bus.branch = zero_q;
                        bus.done   = 1'b1;
                    end
                    CLS_B: begin
                        bus.branch = 1'b1;
                        bus.done   = 1'b1;
                    end
                    default: bus.alu_op = ALU_NONE;
                endcase
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_CBZ || cls_q == CLS_B) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls_q == CLS_LOAD) begin
                    bus.mem_read_dm = 1'b1;
                    state_d         = ST_WB;
                end else begin
                    bus.mem_write_dm = 1'b1;
                    bus.done         = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            ST_WB: begin
                bus.reg_write_rf = 1'b1;
                bus.mux3         = (cls_q != CLS_LOAD);
                bus.done         = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_ERR: begin
                bus.illegal_op = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Randomized self-checking bench: per-cycle output traces vs a per-instruction timeline model.
// Latency: n/a.
// Backpressure: exercises ignored instr_valid and opcode churn while busy.
module tb_legv8_multicycle_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    localparam int K_ILL  = 0;
    localparam int K_ADD  = 1;
    localparam int K_SUB  = 2;
    localparam int K_MUL  = 3;
    localparam int K_DIV  = 4;
    localparam int K_LDUR = 5;
    localparam int K_STUR = 6;
    localparam int K_CBZ  = 7;
    localparam int K_B    = 8;

    localparam logic [11:0] IDLE_VEC = 12'h800;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl_if bus ();

    legv8_multicycle_ctrl #(
        .OPCODE_W (11),
        .ALU_OP_W (3),
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (rdy alu[3] m2 m3 rd wr rw br done ill)", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] observe();
        return {bus.instr_ready, bus.alu_op, bus.mux2, bus.mux3, bus.mem_read_dm,
                bus.mem_write_dm, bus.reg_write_rf, bus.branch, bus.done, bus.illegal_op};
    endfunction

    function automatic bit is_legal(input logic [10:0] opc);
        casez (opc)
            11'b10001011000, 11'b11001011000, 11'b10011011000, 11'b10011010110,
            11'b11111000010, 11'b11111000000, 11'b10110100???, 11'b000101?????: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [10:0] make_opcode(input int kind);
        logic [10:0] r;
        r = 11'($urandom);
        case (kind)
            K_ADD:  return 11'b10001011000;
            K_SUB:  return 11'b11001011000;
            K_MUL:  return 11'b10011011000;
            K_DIV:  return 11'b10011010110;
            K_LDUR: return 11'b11111000010;
            K_STUR: return 11'b11111000000;
            K_CBZ:  return {8'b10110100, r[2:0]};
            K_B:    return {6'b000101, r[4:0]};
            default: begin
                while (is_legal(r)) r = 11'($urandom);
                return r;
            end
        endcase
    endfunction

    // Cycles from the accept cycle (cycle 0) to the retiring/flagging cycle
    function automatic int latency(input int kind);
        case (kind)
            K_ADD, K_SUB, K_STUR: return 3;
            K_MUL:                return 2 + MUL_LAT;
            K_DIV:                return 2 + DIV_LAT;
            K_LDUR:               return 4;
            default:              return 2;
        endcase
    endfunction

    // Expected output vector in cycle k (1..lat) after the accept cycle
    function automatic logic [11:0] expected(input int kind, input int k, input bit z);
        logic [11:0] e;
        int lat, exec_last;
        e = '0;
        lat = latency(kind);
        exec_last = (kind == K_ILL) ? 1 :
                    (kind == K_LDUR || kind == K_STUR || kind == K_CBZ || kind == K_B) ? 2 : lat - 1;
        if (k >= 2 && k <= exec_last) begin
            case (kind)
                K_ADD:         e[10:8] = 3'b010;
                K_SUB:         e[10:8] = 3'b001;
                K_MUL:         e[10:8] = 3'b100;
                K_DIV:         e[10:8] = 3'b011;
                K_LDUR, K_STUR: begin e[10:8] = 3'b010; e[7] = 1'b1; end
                K_CBZ:         e[10:8] = 3'b111;
                default:       e[10:8] = 3'b000;
            endcase
        end
        if (kind == K_LDUR && k == 3) e[5] = 1'b1;
        if (k == lat) begin
            if (kind == K_ILL) begin
                e[0] = 1'b1;
            end else begin
                e[1] = 1'b1;
                case (kind)
                    K_STUR: e[4] = 1'b1;
                    K_B:    e[2] = 1'b1;
                    K_CBZ:  e[2] = z;
                    default: begin
                        e[3] = 1'b1;
                        e[6] = (kind != K_LDUR);
                    end
                endcase
            end
        end
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic run_instr(input string name, input int kind, input logic [10:0] opc,
                             input bit z, input int abort_at);
        int lat;
        lat = latency(kind);
        bus.instr_valid = 1'b1;
        bus.opcode      = opc;
        bus.zero_flag   = z;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", name, k), observe(), expected(kind, k, z));
            if (abort_at != 0 && k == abort_at) begin
                rst_n = 1'b0;
                bus.instr_valid = 1'b0;
                @(negedge clk);
                check($sformatf("%s rst", name), observe(), IDLE_VEC);
                rst_n = 1'b1;
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    check($sformatf("%s post_rst%0d", name, j), observe(), IDLE_VEC);
                end
                return;
            end
            // Busy-time churn must not be accepted or alter the latched instruction
            if (k < lat) begin
                bus.instr_valid = 1'($urandom);
                bus.opcode      = 11'($urandom);
            end else begin
                bus.instr_valid = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("%s idle", name), observe(), IDLE_VEC);
    endtask

    initial begin
        int kind;
        bit z;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.zero_flag   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", observe(), IDLE_VEC);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", observe(), IDLE_VEC);

        run_instr("add",   K_ADD,  11'b10001011000, 1'b0, 0);
        run_instr("sub",   K_SUB,  11'b11001011000, 1'b1, 0);
        run_instr("mul",   K_MUL,  11'b10011011000, 1'b0, 0);
        run_instr("sdiv",  K_DIV,  11'b10011010110, 1'b0, 0);
        run_instr("ldur",  K_LDUR, 11'b11111000010, 1'b0, 0);
        run_instr("stur",  K_STUR, 11'b11111000000, 1'b0, 0);
        run_instr("cbz_z1", K_CBZ, 11'b10110100101, 1'b1, 0);
        run_instr("cbz_z0", K_CBZ, 11'b10110100000, 1'b0, 0);
        run_instr("b",     K_B,    11'b00010100000, 1'b0, 0);
        run_instr("ill0",  K_ILL,  11'b00000000000, 1'b0, 0);
        run_instr("sdiv_abort", K_DIV, 11'b10011010110, 1'b0, 4);
        run_instr("add_after_abort", K_ADD, 11'b10001011000, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 8);
            z    = 1'($urandom);
            run_instr($sformatf("rnd%0d_k%0d", i, kind), kind, make_opcode(kind), z, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
